// File: rtl/branch_recovery_arbiter.sv
// Picks the oldest mispredicted branch across the integer lanes and sequences
// one recovery request at a time, parking an older late mispredict as pending.
//
// state | meaning
// IDLE  | no recovery outstanding
// REQ   | request presented, waiting for handshake
// WAIT  | request accepted, waiting for recovery completion
module branch_recovery_arbiter #(
  parameter int LANES    = 2,
  parameter int AL_PTR_W = 6,
  parameter int PC_W     = 32,
  parameter int CNT_W    = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [LANES-1:0]          i_br_valid,
  input  logic [LANES-1:0]          i_br_mispred,
  input  logic [LANES*AL_PTR_W-1:0] i_br_al_ptr,
  input  logic [LANES*PC_W-1:0]     i_br_next_pc,
  input  logic [AL_PTR_W-1:0]       i_al_head_ptr,
  output logic                      o_req_valid,
  output logic [AL_PTR_W-1:0]       o_req_al_ptr,
  output logic [PC_W-1:0]           o_req_next_pc,
  input  logic                      i_req_ready,
  input  logic                      i_rec_done,
  output logic                      o_busy,
  output logic [CNT_W-1:0]          o_drop_count
);

  localparam int DW = $clog2(LANES + 1) + 1;
  localparam int SW = ((CNT_W > DW) ? CNT_W : DW) + 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t              r_state;
  logic                r_req_valid;
  logic                r_busy;
  logic [AL_PTR_W-1:0] r_held_ptr;
  logic [PC_W-1:0]     r_held_pc;
  logic                r_pend_valid;
  logic [AL_PTR_W-1:0] r_pend_ptr;
  logic [PC_W-1:0]     r_pend_pc;
  logic [CNT_W-1:0]    r_drop_count;

  logic                w_cand;
  logic [AL_PTR_W-1:0] w_cand_ptr;
  logic [PC_W-1:0]     w_cand_pc;
  logic [AL_PTR_W-1:0] w_cand_age;
  logic [AL_PTR_W-1:0] w_lane_age;
  logic [DW-1:0]       w_nqual;
  logic [AL_PTR_W-1:0] w_held_age;
  logic [AL_PTR_W-1:0] w_pend_age;
  logic                w_older_held;
  logic                w_eff_valid;
  logic [AL_PTR_W-1:0] w_eff_ptr;
  logic [PC_W-1:0]     w_eff_pc;
  logic [DW-1:0]       w_drops;
  logic [SW-1:0]       w_sum;
  logic [CNT_W-1:0]    w_drop_next;

  // Oldest qualifying lane wins; strict compare keeps the lowest lane on ties.
  always_comb begin
    w_cand     = 1'b0;
    w_cand_ptr = '0;
    w_cand_pc  = '0;
    w_cand_age = '0;
    w_lane_age = '0;
    w_nqual    = '0;
    for (int i = 0; i < LANES; i++) begin
      if (i_br_valid[i] && i_br_mispred[i]) begin
        w_nqual    = w_nqual + DW'(1);
        w_lane_age = i_br_al_ptr[i*AL_PTR_W +: AL_PTR_W] - i_al_head_ptr;
        if (!w_cand || (w_lane_age < w_cand_age)) begin
          w_cand     = 1'b1;
          w_cand_age = w_lane_age;
          w_cand_ptr = i_br_al_ptr[i*AL_PTR_W +: AL_PTR_W];
          w_cand_pc  = i_br_next_pc[i*PC_W +: PC_W];
        end
      end
    end
  end

  // Pending as it would look after absorbing this cycle's candidate.
  always_comb begin
    w_held_age   = r_held_ptr - i_al_head_ptr;
    w_pend_age   = r_pend_ptr - i_al_head_ptr;
    w_older_held = w_cand && (w_cand_age < w_held_age);
    w_eff_valid  = r_pend_valid || w_older_held;
    w_eff_ptr    = r_pend_ptr;
    w_eff_pc     = r_pend_pc;
    if (w_older_held && (!r_pend_valid || (w_cand_age < w_pend_age))) begin
      w_eff_ptr = w_cand_ptr;
      w_eff_pc  = w_cand_pc;
    end
  end

  // In WAIT with a pending already held, exactly one of candidate/pending is lost.
  always_comb begin
    w_drops = '0;
    if (w_cand) w_drops = w_nqual - DW'(1);
    if (w_cand && (((r_state == S_REQ) && !w_older_held) ||
                   ((r_state == S_WAIT) && (!w_older_held || r_pend_valid))))
      w_drops = w_drops + DW'(1);
    w_sum       = SW'(r_drop_count) + SW'(w_drops);
    w_drop_next = (w_sum > SW'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_req_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_held_ptr   <= '0;
      r_held_pc    <= '0;
      r_pend_valid <= 1'b0;
      r_pend_ptr   <= '0;
      r_pend_pc    <= '0;
      r_drop_count <= '0;
    end else begin
      r_drop_count <= w_drop_next;
      case (r_state)
        S_IDLE: begin
          if (w_cand) begin
            r_held_ptr  <= w_cand_ptr;
            r_held_pc   <= w_cand_pc;
            r_state     <= S_REQ;
            r_req_valid <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        S_REQ: begin
          if (i_req_ready) begin
            r_state      <= S_WAIT;
            r_req_valid  <= 1'b0;
            r_pend_valid <= w_eff_valid;
            r_pend_ptr   <= w_eff_ptr;
            r_pend_pc    <= w_eff_pc;
          end else if (w_older_held) begin
            r_held_ptr <= w_cand_ptr;
            r_held_pc  <= w_cand_pc;
          end
        end
        S_WAIT: begin
          if (i_rec_done) begin
            r_pend_valid <= 1'b0;
            if (w_eff_valid) begin
              r_held_ptr  <= w_eff_ptr;
              r_held_pc   <= w_eff_pc;
              r_state     <= S_REQ;
              r_req_valid <= 1'b1;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_pend_valid <= w_eff_valid;
            r_pend_ptr   <= w_eff_ptr;
            r_pend_pc    <= w_eff_pc;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_req_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign o_req_valid   = r_req_valid;
  assign o_req_al_ptr  = r_held_ptr;
  assign o_req_next_pc = r_held_pc;
  assign o_busy        = r_busy;
  assign o_drop_count  = r_drop_count;

endmodule

// File: tb/tb_branch_recovery_arbiter.sv
// Directed bench: expected requests go into a queue, a negedge monitor pops
// and compares on every handshake; status outputs are checked inline.
module tb_branch_recovery_arbiter;

  localparam int LANES = 2;
  localparam int AW    = 6;
  localparam int PW    = 32;
  localparam int CW    = 2;

  typedef struct {
    logic [AW-1:0] ptr;
    logic [PW-1:0] pc;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [LANES-1:0]    br_valid = '0;
  logic [LANES-1:0]    br_mispred = '0;
  logic [LANES*AW-1:0] br_ptr = '0;
  logic [LANES*PW-1:0] br_pc = '0;
  logic [AW-1:0]       head = '0;
  logic                req_ready = 1'b0;
  logic                rec_done = 1'b0;
  logic                o_req_valid;
  logic [AW-1:0]       o_req_al_ptr;
  logic [PW-1:0]       o_req_next_pc;
  logic                o_busy;
  logic [CW-1:0]       o_drop_count;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   exp_drop = 0;

  branch_recovery_arbiter #(.LANES(LANES), .AL_PTR_W(AW), .PC_W(PW), .CNT_W(CW)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_br_valid    (br_valid),
    .i_br_mispred  (br_mispred),
    .i_br_al_ptr   (br_ptr),
    .i_br_next_pc  (br_pc),
    .i_al_head_ptr (head),
    .o_req_valid   (o_req_valid),
    .o_req_al_ptr  (o_req_al_ptr),
    .o_req_next_pc (o_req_next_pc),
    .i_req_ready   (req_ready),
    .i_rec_done    (rec_done),
    .o_busy        (o_busy),
    .o_drop_count  (o_drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lane(input int i, input logic [AW-1:0] p, input logic [PW-1:0] pc);
    br_valid[i]          = 1'b1;
    br_mispred[i]        = 1'b1;
    br_ptr[i*AW +: AW]   = p;
    br_pc[i*PW +: PW]    = pc;
  endtask

  task automatic clr();
    br_valid   = '0;
    br_mispred = '0;
  endtask

  task automatic push(input logic [AW-1:0] p, input logic [PW-1:0] pc);
    exp_t e;
    e.ptr = p;
    e.pc  = pc;
    q.push_back(e);
  endtask

  task automatic finish_req();
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    rec_done  = 1'b1;
    tick();
    rec_done  = 1'b0;
  endtask

  // Monitor: every accepted request must match the next expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && o_req_valid && req_ready) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_req: got ptr %0h want none", o_req_al_ptr);
        end else begin
          e = q.pop_front();
          chk("req_ptr", 32'(o_req_al_ptr), 32'(e.ptr));
          chk("req_pc", o_req_next_pc, e.pc);
        end
      end
    end
  end

  initial begin
    #2;
    chk("rst_valid", 32'(o_req_valid), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_drop", 32'(o_drop_count), 0);
    chk("rst_ptr", 32'(o_req_al_ptr), 0);
    chk("rst_pc", o_req_next_pc, 0);
    #1 rst_n = 1'b1;
    tick();

    // single lane, latency 1
    lane(0, 6'd5, 32'h1000);
    push(6'd5, 32'h1000);
    tick();
    clr();
    chk("single_valid", 32'(o_req_valid), 1);
    chk("single_ptr", 32'(o_req_al_ptr), 5);
    chk("single_pc", o_req_next_pc, 32'h1000);
    chk("single_busy", 32'(o_busy), 1);
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    chk("wait_valid", 32'(o_req_valid), 0);
    chk("wait_busy", 32'(o_busy), 1);
    rec_done = 1'b1;
    tick();
    rec_done = 1'b0;
    chk("idle_busy", 32'(o_busy), 0);

    // dual lanes same cycle, then wrapped age compare
    lane(0, 6'd9, 32'h2000);
    lane(1, 6'd3, 32'h3000);
    push(6'd3, 32'h3000);
    tick();
    clr();
    exp_drop = sat(exp_drop + 1);
    chk("dual_ptr", 32'(o_req_al_ptr), 3);
    chk("dual_drop", 32'(o_drop_count), 32'(exp_drop));
    finish_req();
    head = 6'd60;
    lane(0, 6'd1, 32'h4000);
    lane(1, 6'd62, 32'h5000);
    push(6'd62, 32'h5000);
    tick();
    clr();
    exp_drop = sat(exp_drop + 1);
    chk("wrap_ptr", 32'(o_req_al_ptr), 62);
    chk("wrap_drop", 32'(o_drop_count), 32'(exp_drop));
    finish_req();
    head = 6'd0;

    // asynchronous reset while in REQ
    lane(0, 6'd20, 32'h6000);
    tick();
    clr();
    chk("pre_rst_valid", 32'(o_req_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(o_req_valid), 0);
    chk("async_rst_busy", 32'(o_busy), 0);
    chk("async_rst_drop", 32'(o_drop_count), 0);
    exp_drop = 0;
    #1 rst_n = 1'b1;
    tick();

    // replacement in REQ, then a younger candidate dropped
    lane(0, 6'd7, 32'h7000);
    tick();
    clr();
    chk("repl_first_ptr", 32'(o_req_al_ptr), 7);
    lane(1, 6'd4, 32'h8000);
    tick();
    clr();
    chk("repl_ptr", 32'(o_req_al_ptr), 4);
    chk("repl_pc", o_req_next_pc, 32'h8000);
    chk("repl_drop", 32'(o_drop_count), 32'(exp_drop));
    lane(0, 6'd8, 32'h9000);
    tick();
    clr();
    exp_drop = sat(exp_drop + 1);
    chk("younger_ptr", 32'(o_req_al_ptr), 4);
    chk("younger_drop", 32'(o_drop_count), 32'(exp_drop));
    push(6'd4, 32'h8000);
    finish_req();

    // pending capture in WAIT
    lane(0, 6'd10, 32'hA000);
    push(6'd10, 32'hA000);
    tick();
    clr();
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    lane(0, 6'd6, 32'hB000);
    lane(1, 6'd12, 32'hC000);
    tick();
    clr();
    exp_drop = sat(exp_drop + 1);
    chk("pend_drop", 32'(o_drop_count), 32'(exp_drop));
    chk("pend_valid_low", 32'(o_req_valid), 0);
    rec_done = 1'b1;
    push(6'd6, 32'hB000);
    tick();
    rec_done = 1'b0;
    chk("pend_req_valid", 32'(o_req_valid), 1);
    chk("pend_req_ptr", 32'(o_req_al_ptr), 6);
    chk("pend_req_pc", o_req_next_pc, 32'hB000);
    finish_req();

    // saturation of the drop counter
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    exp_drop = 0;
    tick();
    lane(0, 6'd10, 32'hD000);
    push(6'd10, 32'hD000);
    tick();
    clr();
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      lane(0, 6'd20, 32'hE000);
      tick();
      exp_drop = sat(exp_drop + 1);
      chk("sat_drop", 32'(o_drop_count), 32'(exp_drop));
    end
    clr();
    rec_done = 1'b1;
    tick();
    rec_done = 1'b0;
    chk("sat_idle_valid", 32'(o_req_valid), 0);
    chk("sat_idle_busy", 32'(o_busy), 0);
    chk("sat_hold", 32'(o_drop_count), 3);

    tick();
    chk("queue_empty", 32'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
